// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register index, ALU op, control bundle and the
// ID/EX hazard FSM states. ZERO_REG is also used by the forwarding unit.
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [3:0] alu_op_t;

    // Register 31 is the hard-wired zero register in this core.
    localparam reg_idx_t ZERO_REG = 5'd31;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_t alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } ex_state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by
// the instruction currently in ID. Writes to ZERO_REG never create a hazard.
import pipeline_pkg::*;

module load_use_detect (
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    input  logic     id_uses_rs2,
    output logic     hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign hazard    = ex_valid && ex_mem_read && (ex_rd != ZERO_REG) &&
                       id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection.
// Handshake: ex_stall=1 means EX/MEM cannot accept, so this stage holds every
// register; stall_if_id=1 tells PC and IF/ID to hold their contents this
// cycle. flush overrides both and kills the instruction in EX.
// Optional feature macro: ID_EX_PERF_CNT_EN adds perf_bubbles/perf_flushes.
import pipeline_pkg::*;

module id_ex_stage #(
    parameter int DATA_W           = 64,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  reg_idx_t          id_rs1,
    input  reg_idx_t          id_rs2,
    input  logic              id_uses_rs2,
    input  reg_idx_t          id_rd,
    input  ctrl_t             id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              stall_if_id,
    output logic              ex_valid,
    output reg_idx_t          ex_rs1,
    output reg_idx_t          ex_rs2,
    output reg_idx_t          ex_rd,
    output ctrl_t             ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output ex_state_e         state_dbg
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes
`endif
);

    localparam int CNT_W = $clog2(LOAD_USE_BUBBLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    ex_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             hazard;
    logic             take_bubble;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    // A bubble goes into EX on the first hazard cycle and every BUBBLE cycle.
    assign take_bubble = ((state == RUN) && hazard) || (state == BUBBLE);
    assign stall_if_id = !flush && (ex_stall || take_bubble);
    assign state_dbg   = state;

    // Bubble FSM: RUN detects the hazard, BUBBLE counts down the remaining bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (flush) begin
            state <= RUN;
            cnt   <= '0;
        end else if (ex_stall) begin
            state <= state;
            cnt   <= cnt;
        end else if ((state == RUN) && hazard) begin
            if (LOAD_USE_BUBBLES > 1) begin
                state <= BUBBLE;
                cnt   <= CNT_INIT;
            end
        end else if (state == BUBBLE) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_LAST) begin
                state <= RUN;
            end
        end
    end

    // Pipeline register: flush > ex_stall > bubble > load.
    // Data fields are left untouched on flush/bubble; only valid, control
    // and indices are cleared so the forwarding unit sees nothing live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
        end else if (flush || (!ex_stall && take_bubble)) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
        end else if (!ex_stall) begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_pc    <= id_pc;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Event counters: injected bubbles and flushes that killed something.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (flush && (ex_valid || id_valid)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
            if (!flush && !ex_stall && take_bubble) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Three instances share one stimulus stream,
// built with LOAD_USE_BUBBLES = 1, 2, 3 (index 0, 1, 2); each scenario checks
// the instance it targets and resets all of them beforehand.
import pipeline_pkg::*;

module tb_id_ex_stage;

    localparam int DW = 64;

    localparam ctrl_t CTRL_LD  = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                                   mem_to_reg: 1'b1, alu_src: 1'b1, alu_op: 4'h0};
    localparam ctrl_t CTRL_ADD = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                                   mem_to_reg: 1'b0, alu_src: 1'b0, alu_op: 4'h2};
    localparam ctrl_t CTRL_SW  = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1,
                                   mem_to_reg: 1'b0, alu_src: 1'b1, alu_op: 4'h0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic          id_valid, id_uses_rs2, ex_stall, flush;
    reg_idx_t      id_rs1, id_rs2, id_rd;
    ctrl_t         id_ctrl;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc;

    // ---------------- per-instance outputs ----------------
    logic          stall_o [3];
    logic          valid_o [3];
    reg_idx_t      rs1_o   [3];
    reg_idx_t      rs2_o   [3];
    reg_idx_t      rd_o    [3];
    ctrl_t         ctrl_o  [3];
    logic [DW-1:0] rd1_o   [3];
    logic [DW-1:0] rd2_o   [3];
    logic [DW-1:0] imm_o   [3];
    logic [DW-1:0] pc_o    [3];
    ex_state_e     state_o [3];
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   pbub_o  [3];
    logic [31:0]   pflu_o  [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        id_ex_stage #(.DATA_W(DW), .LOAD_USE_BUBBLES(g + 1)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .id_valid    (id_valid),
            .id_rs1      (id_rs1),
            .id_rs2      (id_rs2),
            .id_uses_rs2 (id_uses_rs2),
            .id_rd       (id_rd),
            .id_ctrl     (id_ctrl),
            .id_rd1      (id_rd1),
            .id_rd2      (id_rd2),
            .id_imm      (id_imm),
            .id_pc       (id_pc),
            .ex_stall    (ex_stall),
            .flush       (flush),
            .stall_if_id (stall_o[g]),
            .ex_valid    (valid_o[g]),
            .ex_rs1      (rs1_o[g]),
            .ex_rs2      (rs2_o[g]),
            .ex_rd       (rd_o[g]),
            .ex_ctrl     (ctrl_o[g]),
            .ex_rd1      (rd1_o[g]),
            .ex_rd2      (rd2_o[g]),
            .ex_imm      (imm_o[g]),
            .ex_pc       (pc_o[g]),
            .state_dbg   (state_o[g])
`ifdef ID_EX_PERF_CNT_EN
            ,
            .perf_bubbles (pbub_o[g]),
            .perf_flushes (pflu_o[g])
`endif
        );
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input reg_idx_t rs1, input reg_idx_t rs2,
                            input logic u2, input reg_idx_t rd, input ctrl_t c,
                            input logic [DW-1:0] pc);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        id_rd       = rd;
        id_ctrl     = c;
        id_rd1      = pc ^ 64'h1111;
        id_rd2      = pc ^ 64'h2222;
        id_imm      = pc + 64'h40;
        id_pc       = pc;
    endtask

    task automatic drive_idle();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, CTRL_NOP, 64'h0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ex_stall = 1'b0;
        flush    = 1'b0;
        drive_idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        ex_stall = 1'b0;
        flush    = 1'b0;
        drive_idle();
        tick();

        // Reset state on every instance.
        for (int g = 0; g < 3; g++) begin
            check("rst_valid", 64'(valid_o[g]), 64'd0);
            check("rst_ctrl",  64'(ctrl_o[g]),  64'd0);
            check("rst_rd",    64'(rd_o[g]),    64'd0);
            check("rst_pc",    64'(pc_o[g]),    64'd0);
            check("rst_stall", 64'(stall_o[g]), 64'd0);
        end
        rst_n = 1'b1;

        // ld x5 then add x6,x5,x7 with one bubble.
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h100);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, CTRL_ADD, 64'h104);
        settle();
        check("lu_stall",   64'(stall_o[0]), 64'd1);
        check("lu_ld_rd",   64'(rd_o[0]),    64'd5);
        check("lu_ld_ctrl", 64'(ctrl_o[0]),  64'(CTRL_LD));
        check("lu_ld_imm",  imm_o[0],        64'h140);
        tick();
        check("lu_bub_valid", 64'(valid_o[0]), 64'd0);
        check("lu_bub_ctrl",  64'(ctrl_o[0]),  64'd0);
        check("lu_bub_rs1",   64'(rs1_o[0]),   64'd0);
        check("lu_bub_stall", 64'(stall_o[0]), 64'd0);
        tick();
        check("lu_add_valid", 64'(valid_o[0]), 64'd1);
        check("lu_add_rd",    64'(rd_o[0]),    64'd6);
        check("lu_add_rs1",   64'(rs1_o[0]),   64'd5);
        check("lu_add_rs2",   64'(rs2_o[0]),   64'd7);
        check("lu_add_ctrl",  64'(ctrl_o[0]),  64'(CTRL_ADD));
        check("lu_add_pc",    pc_o[0],         64'h104);
        check("lu_add_rd1",   rd1_o[0],        64'h1015);
        check("lu_add_rd2",   rd2_o[0],        64'h2326);

        // ld x31 never hazards; rs2 only counts when id_uses_rs2.
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd31, CTRL_LD, 64'h200);
        tick();
        drive_id(1'b1, 5'd31, 5'd31, 1'b1, 5'd6, CTRL_ADD, 64'h204);
        settle();
        check("z_stall", 64'(stall_o[0]), 64'd0);
        tick();
        check("z_next_valid", 64'(valid_o[0]), 64'd1);
        check("z_next_rd",    64'(rd_o[0]),    64'd6);
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h300);
        tick();
        drive_id(1'b1, 5'd2, 5'd5, 1'b0, 5'd0, CTRL_SW, 64'h304);
        settle();
        check("rs2_unused_stall", 64'(stall_o[0]), 64'd0);
        id_uses_rs2 = 1'b1;
        settle();
        check("rs2_used_stall", 64'(stall_o[0]), 64'd1);
        tick();
        check("rs2_used_bub", 64'(valid_o[0]), 64'd0);

        // Hazard and flush together: flush wins, no extra bubble afterwards.
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h400);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, CTRL_ADD, 64'h404);
        flush = 1'b1;
        settle();
        check("fl_stall", 64'(stall_o[0]), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        check("fl_valid", 64'(valid_o[0]), 64'd0);
        check("fl_ctrl",  64'(ctrl_o[0]),  64'd0);
        check("fl_state", 64'(state_o[0]), 64'(RUN));
        check("fl_stall_after", 64'(stall_o[0]), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        check("fl_perf_flushes", 64'(pflu_o[0]), 64'd1);
        check("fl_perf_bubbles", 64'(pbub_o[0]), 64'd0);
`endif
        tick();
        check("fl_add_valid", 64'(valid_o[0]), 64'd1);
        check("fl_add_rd",    64'(rd_o[0]),    64'd6);

        // ex_stall for 3 cycles with hazard present, bubble after release.
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h500);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, CTRL_ADD, 64'h504);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_stall", 64'(stall_o[0]), 64'd1);
            check("st_valid", 64'(valid_o[0]), 64'd1);
            check("st_rd",    64'(rd_o[0]),    64'd5);
            check("st_pc",    pc_o[0],         64'h500);
            tick();
        end
        ex_stall = 1'b0;
        settle();
        check("st_rel_stall", 64'(stall_o[0]), 64'd1);
        check("st_rel_valid", 64'(valid_o[0]), 64'd1);
        tick();
        check("st_bub_valid", 64'(valid_o[0]), 64'd0);
        tick();
        check("st_add_valid", 64'(valid_o[0]), 64'd1);
        check("st_add_rd",    64'(rd_o[0]),    64'd6);

        // Two-bubble instance: reset asserted mid-BUBBLE.
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h600);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, CTRL_ADD, 64'h604);
        settle();
        check("mb_stall0", 64'(stall_o[1]), 64'd1);
        tick();
        check("mb_state", 64'(state_o[1]), 64'(BUBBLE));
        check("mb_stall1", 64'(stall_o[1]), 64'd1);
        rst_n = 1'b0;
        settle();
        check("mb_rst_valid", 64'(valid_o[1]), 64'd0);
        check("mb_rst_rd",    64'(rd_o[1]),    64'd0);
        check("mb_rst_pc",    pc_o[1],         64'h0);
        check("mb_rst_imm",   imm_o[1],        64'h0);
        check("mb_rst_ctrl",  64'(ctrl_o[1]),  64'd0);
        check("mb_rst_state", 64'(state_o[1]), 64'(RUN));
        check("mb_rst_stall", 64'(stall_o[1]), 64'd0);
        tick();
        rst_n = 1'b1;

        // Three-bubble instance: stall high exactly 3 cycles.
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, CTRL_LD, 64'h700);
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, CTRL_ADD, 64'h704);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("b3_stall", 64'(stall_o[2]), (i < 3) ? 64'd1 : 64'd0);
            check("b3_valid", 64'(valid_o[2]), (i == 0) ? 64'd1 : 64'd0);
            tick();
        end
        check("b3_add_valid", 64'(valid_o[2]), 64'd1);
        check("b3_add_rd",    64'(rd_o[2]),    64'd6);
        check("b3_add_pc",    pc_o[2],         64'h704);
`ifdef ID_EX_PERF_CNT_EN
        check("b3_perf_bubbles", 64'(pbub_o[2]), 64'd3);
        check("b3_perf_flushes", 64'(pflu_o[2]), 64'd0);
`endif

        drive_idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
